// File: rtl/frequency_reader_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : frequency_reader_pkg
// Description : Shared definitions for the frequency result reader.
//               - state_e         : reader state machine encoding
//               - RESP_OKAY       : AXI OKAY response code
//               - REGISTER_STRIDE : byte distance between result registers
// Revision    : 1.0 - initial release
// ============================================================================
package frequency_reader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_DATA = 3'd2,
      ST_PUSH = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   localparam logic [1:0] RESP_OKAY       = 2'b00;
   localparam int         REGISTER_STRIDE = 4;

endpackage
`default_nettype wire

// File: rtl/frequency_reader_watchdog.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : frequency_reader_watchdog
// Description : Wait-cycle counter for the result reader. Counts enabled
//               cycles since the last clear and flags the cycle on which the
//               LIMIT-th consecutive enabled cycle is reached.
// Ports       : clk     - clock, rising edge
//               rst_n   - asynchronous active-low reset
//               clear   - restart counting from zero on the next cycle
//               enable  - count this cycle
//               expired - this is the LIMIT-th enabled cycle since clear
// Revision    : 1.0 - initial release
// ============================================================================
module frequency_reader_watchdog #(
   parameter int LIMIT = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Saturate at LIMIT-1 so the counter never wraps while stalled.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count_q != CW'(LIMIT - 1))) begin
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = enable & (count_q == CW'(LIMIT - 1));

endmodule
`default_nettype wire

// File: rtl/frequency_result_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : frequency_result_reader
// Description : AXI4-Lite read-only master. On a rising edge of irq it reads
//               result registers 1..REGISTERS_NUMBER, one transaction at a
//               time, and emits each one on a valid/ready result stream.
// Ports       : m00_axi_*      - AXI4-Lite read channels (AR, R)
//               irq            - completion level from the analyzer manager
//               result_*       - result stream (index, data, error flag)
//               busy / done    - run in progress / one-cycle end-of-run pulse
//               error          - sticky: bad RRESP or timeout in this run
// Options     : FREQUENCY_READER_TIMEOUT_EN - abort the run when a slave
//               stalls AR or R for TIMEOUT_CYCLES cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module frequency_result_reader
   import frequency_reader_pkg::*;
#(
   parameter int C_M00_AXI_ADDR_WIDTH = 10,
   parameter int C_M00_AXI_DATA_WIDTH = 32,
   parameter int BASE_ADDRESS         = 0,
   parameter int REGISTERS_NUMBER     = 6,
   parameter int TIMEOUT_CYCLES       = 1024
) (
   input  logic                            m00_axi_aclk,
   input  logic                            m00_axi_aresetn,
   input  logic                            irq,
   output logic [C_M00_AXI_ADDR_WIDTH-1:0] m00_axi_araddr,
   output logic [2:0]                      m00_axi_arprot,
   output logic                            m00_axi_arvalid,
   input  logic                            m00_axi_arready,
   input  logic [C_M00_AXI_DATA_WIDTH-1:0] m00_axi_rdata,
   input  logic [1:0]                      m00_axi_rresp,
   input  logic                            m00_axi_rvalid,
   output logic                            m00_axi_rready,
   output logic                            result_valid,
   input  logic                            result_ready,
   output logic [2:0]                      result_index,
   output logic [C_M00_AXI_DATA_WIDTH-1:0] result_data,
   output logic                            result_error,
   output logic                            busy,
   output logic                            done,
   output logic                            error
);

   generate
      if (C_M00_AXI_DATA_WIDTH != 32) begin : g_bad_data_width
         $error("frequency_result_reader supports only a 32-bit data bus");
      end
      if ((REGISTERS_NUMBER < 1) || (REGISTERS_NUMBER > 7)) begin : g_bad_reg_count
         $error("REGISTERS_NUMBER must fit the 3-bit result index (1..7)");
      end
      if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
         $error("TIMEOUT_CYCLES must be at least 1");
      end
   endgenerate

   function automatic logic [C_M00_AXI_ADDR_WIDTH-1:0] reg_addr(input logic [2:0] k);
      reg_addr = C_M00_AXI_ADDR_WIDTH'(BASE_ADDRESS + REGISTER_STRIDE * int'(k));
   endfunction

   state_e                          state_q, state_d;
   logic                            irq_q;
   logic [2:0]                      index_q, index_d;
   logic [C_M00_AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic                            arvalid_q, arvalid_d;
   logic                            rready_q, rready_d;
   logic                            result_valid_q, result_valid_d;
   logic [2:0]                      result_index_q, result_index_d;
   logic [C_M00_AXI_DATA_WIDTH-1:0] result_data_q, result_data_d;
   logic                            result_error_q, result_error_d;
   logic                            busy_q, busy_d;
   logic                            done_q, done_d;
   logic                            error_q, error_d;

   logic w_trigger;
   logic w_rresp_err;
   logic w_timeout;

   // Only a fresh rising edge starts a run; a level held high from a
   // previous run, or an edge seen while busy, is ignored.
   assign w_trigger   = irq & ~irq_q;
   assign w_rresp_err = (m00_axi_rresp != RESP_OKAY);

`ifdef FREQUENCY_READER_TIMEOUT_EN
   logic w_waiting;
   logic w_state_change;

   assign w_waiting      = (state_q == ST_ADDR) || (state_q == ST_DATA);
   assign w_state_change = (state_d != state_q);

   frequency_reader_watchdog #(
      .LIMIT   (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (m00_axi_aclk),
      .rst_n   (m00_axi_aresetn),
      .clear   (w_state_change),
      .enable  (w_waiting),
      .expired (w_timeout)
   );
`else
   assign w_timeout = 1'b0;
`endif

   // Outputs are computed for the next state so that every port comes
   // straight from a flop.
   always_comb begin
      state_d        = state_q;
      index_d        = index_q;
      araddr_d       = araddr_q;
      arvalid_d      = arvalid_q;
      rready_d       = rready_q;
      result_valid_d = result_valid_q;
      result_index_d = result_index_q;
      result_data_d  = result_data_q;
      result_error_d = result_error_q;
      busy_d         = busy_q;
      done_d         = 1'b0;
      error_d        = error_q;

      case (state_q)
         ST_IDLE: begin
            if (w_trigger) begin
               state_d   = ST_ADDR;
               index_d   = 3'd1;
               araddr_d  = reg_addr(3'd1);
               arvalid_d = 1'b1;
               busy_d    = 1'b1;
               error_d   = 1'b0;
            end
         end
         ST_ADDR: begin
            if (m00_axi_arready) begin
               state_d   = ST_DATA;
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
            end else if (w_timeout) begin
               state_d   = ST_DONE;
               arvalid_d = 1'b0;
               error_d   = 1'b1;
               done_d    = 1'b1;
            end
         end
         ST_DATA: begin
            // A completed handshake wins over a timeout on the same cycle.
            if (m00_axi_rvalid) begin
               state_d        = ST_PUSH;
               rready_d       = 1'b0;
               result_valid_d = 1'b1;
               result_index_d = index_q;
               result_data_d  = m00_axi_rdata;
               result_error_d = w_rresp_err;
               error_d        = error_q | w_rresp_err;
            end else if (w_timeout) begin
               state_d  = ST_DONE;
               rready_d = 1'b0;
               error_d  = 1'b1;
               done_d   = 1'b1;
            end
         end
         ST_PUSH: begin
            if (result_ready) begin
               result_valid_d = 1'b0;
               if (index_q == 3'(REGISTERS_NUMBER)) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d   = ST_ADDR;
                  index_d   = index_q + 3'd1;
                  araddr_d  = reg_addr(index_q + 3'd1);
                  arvalid_d = 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d        = ST_IDLE;
            arvalid_d      = 1'b0;
            rready_d       = 1'b0;
            result_valid_d = 1'b0;
            busy_d         = 1'b0;
         end
      endcase
   end

   always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
      if (!m00_axi_aresetn) begin
         state_q        <= ST_IDLE;
         irq_q          <= 1'b0;
         index_q        <= '0;
         araddr_q       <= '0;
         arvalid_q      <= 1'b0;
         rready_q       <= 1'b0;
         result_valid_q <= 1'b0;
         result_index_q <= '0;
         result_data_q  <= '0;
         result_error_q <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         error_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         irq_q          <= irq;
         index_q        <= index_d;
         araddr_q       <= araddr_d;
         arvalid_q      <= arvalid_d;
         rready_q       <= rready_d;
         result_valid_q <= result_valid_d;
         result_index_q <= result_index_d;
         result_data_q  <= result_data_d;
         result_error_q <= result_error_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         error_q        <= error_d;
      end
   end

   assign m00_axi_araddr  = araddr_q;
   assign m00_axi_arprot  = 3'b000;
   assign m00_axi_arvalid = arvalid_q;
   assign m00_axi_rready  = rready_q;
   assign result_valid    = result_valid_q;
   assign result_index    = result_index_q;
   assign result_data     = result_data_q;
   assign result_error    = result_error_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign error           = error_q;

endmodule
`default_nettype wire

// File: tb/tb_frequency_result_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_frequency_result_reader
// Description : Self-checking bench for frequency_result_reader. A table of
//               run descriptions (slave latencies, consumer back-pressure,
//               error responses, irq behaviour) is applied one run at a time
//               against an AXI slave / stream consumer model; expectations
//               come from the register-list rules, not from the RTL.
//               Build with FREQUENCY_READER_TIMEOUT_EN to add the timeout run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frequency_result_reader;

   localparam int NREG   = 6;
   localparam int BASE   = 0;
   localparam int BUDGET = 2000;
`ifdef FREQUENCY_READER_TIMEOUT_EN
   localparam int TB_TIMEOUT = 16;
`else
   localparam int TB_TIMEOUT = 1024;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        irq = 1'b0;
   logic [9:0]  araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready = 1'b0;
   logic [31:0] rdata = '0;
   logic [1:0]  rresp = 2'b00;
   logic        rvalid = 1'b0;
   logic        rready;
   logic        result_valid;
   logic        result_ready = 1'b0;
   logic [2:0]  result_index;
   logic [31:0] result_data;
   logic        result_error;
   logic        busy;
   logic        done;
   logic        error;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   frequency_result_reader #(
      .C_M00_AXI_ADDR_WIDTH (10),
      .C_M00_AXI_DATA_WIDTH (32),
      .BASE_ADDRESS         (BASE),
      .REGISTERS_NUMBER     (NREG),
      .TIMEOUT_CYCLES       (TB_TIMEOUT)
   ) dut (
      .m00_axi_aclk    (clk),
      .m00_axi_aresetn (rst_n),
      .irq             (irq),
      .m00_axi_araddr  (araddr),
      .m00_axi_arprot  (arprot),
      .m00_axi_arvalid (arvalid),
      .m00_axi_arready (arready),
      .m00_axi_rdata   (rdata),
      .m00_axi_rresp   (rresp),
      .m00_axi_rvalid  (rvalid),
      .m00_axi_rready  (rready),
      .result_valid    (result_valid),
      .result_ready    (result_ready),
      .result_index    (result_index),
      .result_data     (result_data),
      .result_error    (result_error),
      .busy            (busy),
      .done            (done),
      .error           (error)
   );

   // rr_mode: 0 always ready, 1 toggle every cycle, 2 random.
   // irq_mode: 0 short pulse, 1 re-pulse mid-run then stay high.
   // hang_k: register whose R beat never arrives (0 = none).
   typedef struct {
      int          ar_delay;
      int          r_delay;
      int          rr_mode;
      int          irq_mode;
      int          hang_k;
      logic [7:0]  err_mask;
      logic [31:0] seed;
      int          exp_beats;
      bit          exp_error;
      int          exp_done_n;
   } run_cfg_t;

   task automatic chk(input bit ok, input string name, input longint act, input longint exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   function automatic logic [31:0] data_of(input int k, input logic [31:0] seed);
      return seed + 32'(100 * k);
   endfunction

   // Expectations from the run rules: registers before a hang are read,
   // any bad response or a hang raises error, a fully ready bus costs
   // three cycles per register plus the DONE cycle.
   function automatic run_cfg_t mk(input int ard, input int rd, input int rrm, input int irqm,
                                   input int hang, input logic [7:0] mask, input logic [31:0] seed);
      run_cfg_t c;
      c.ar_delay  = ard;
      c.r_delay   = rd;
      c.rr_mode   = rrm;
      c.irq_mode  = irqm;
      c.hang_k    = hang;
      c.err_mask  = mask;
      c.seed      = seed;
      c.exp_beats = (hang == 0) ? NREG : hang - 1;
      c.exp_error = (hang != 0);
      for (int k = 1; k <= c.exp_beats; k++) if (mask[k]) c.exp_error = 1'b1;
      c.exp_done_n = (ard == 0 && rd == 0 && rrm == 0 && hang == 0) ? 3 * NREG + 1 : 0;
      return c;
   endfunction

   function automatic bit outputs_zero();
      return ({araddr, arprot, arvalid, rready, result_valid, result_index, result_data,
               result_error, busy, done, error} == '0);
   endfunction

   task automatic run_one(input run_cfg_t c, input int id);
      int n = 0, ar_cnt = 0, r_cnt = 0, cur_k = 0, beats = 0, ars = 0, hang_cycles = 0;
      bit has_rd = 0, seen_done = 0, r_tog = 0;
      bit p_arvalid = 0, p_rready = 0, p_rv = 0;
      logic [9:0]  p_araddr = '0;
      logic [2:0]  p_idx = '0;
      logic [31:0] p_data = '0;
      bit          p_err = 0;

      @(negedge clk);
      irq = 1'b1;
      while (!seen_done && n < BUDGET) begin
         @(negedge clk);
         n++;
         // Handshakes completed on the edge just passed.
         if (p_arvalid && arready) begin
            ars++;
            cur_k = ars;
            chk(p_araddr == 10'(BASE + 4 * ars), $sformatf("run%0d araddr%0d", id, ars), p_araddr, BASE + 4 * ars);
            has_rd = 1; r_cnt = 0; ar_cnt = 0;
         end
         if (p_rready && rvalid) has_rd = 0;
         if (p_rv && result_ready) begin
            beats++;
            chk(p_idx == 3'(beats), $sformatf("run%0d index%0d", id, beats), p_idx, beats);
            chk(p_data == data_of(beats, c.seed), $sformatf("run%0d data%0d", id, beats), p_data, data_of(beats, c.seed));
            chk(p_err == c.err_mask[beats], $sformatf("run%0d rerr%0d", id, beats), p_err, c.err_mask[beats]);
         end
         // Protocol rules observed on the current cycle.
         if (n == 1) begin
            chk(arvalid && busy, $sformatf("run%0d start_latency", id), {arvalid, busy}, 2'b11);
            chk(!error, $sformatf("run%0d error_cleared", id), error, 0);
         end
         if (arvalid && p_arvalid && !arready)
            chk(araddr == p_araddr, $sformatf("run%0d araddr_stable", id), araddr, p_araddr);
         if (result_valid && p_rv && !result_ready)
            chk({result_index, result_data, result_error} == {p_idx, p_data, p_err},
                $sformatf("run%0d result_stable", id), result_data, p_data);
         if (arvalid) chk(!has_rd && !result_valid, $sformatf("run%0d one_outstanding", id), {has_rd, result_valid}, 0);
         if (rready) begin
            chk(has_rd, $sformatf("run%0d rready_in_data", id), has_rd, 1);
            if (cur_k == c.hang_k) hang_cycles++;
         end
         if (c.irq_mode == 0 && n == 2) irq = 1'b0;
         if (c.irq_mode == 1 && n == 5) irq = 1'b0;
         if (c.irq_mode == 1 && n == 7) irq = 1'b1;
         if (done) begin
            seen_done = 1;
            chk(beats == c.exp_beats, $sformatf("run%0d beat_count", id), beats, c.exp_beats);
            chk(error == c.exp_error, $sformatf("run%0d error_at_done", id), error, c.exp_error);
            if (c.exp_done_n != 0) chk(n == c.exp_done_n, $sformatf("run%0d done_cycle", id), n, c.exp_done_n);
            if (c.hang_k != 0) chk(hang_cycles == TB_TIMEOUT, $sformatf("run%0d rready_cycles", id), hang_cycles, TB_TIMEOUT);
         end
         // Remember what the DUT presents now, then drive the next cycle.
         p_arvalid = arvalid; p_araddr = araddr; p_rready = rready;
         p_rv = result_valid; p_idx = result_index; p_data = result_data; p_err = result_error;
         arready = arvalid && !has_rd && (ar_cnt >= c.ar_delay);
         if (arvalid && !has_rd) ar_cnt++;
         if (has_rd) begin
            rvalid = (cur_k != c.hang_k) && (r_cnt >= c.r_delay);
            rdata  = data_of(cur_k, c.seed);
            rresp  = c.err_mask[cur_k] ? 2'b10 : 2'b00;
            r_cnt++;
         end else begin
            rvalid = 1'b0;
         end
         case (c.rr_mode)
            0:       result_ready = 1'b1;
            1:       begin r_tog = ~r_tog; result_ready = r_tog; end
            default: result_ready = 1'($urandom_range(0, 1));
         endcase
      end
      if (!seen_done) chk(1'b0, $sformatf("run%0d done_timeout", id), n, BUDGET);
      arready = 1'b0; rvalid = 1'b0;
      @(negedge clk);
      chk(!done && !busy, $sformatf("run%0d done_pulse_busy", id), {done, busy}, 0);
      if (c.irq_mode == 1) begin
         repeat (8) @(negedge clk);
         chk(!busy && !arvalid, $sformatf("run%0d no_retrigger", id), {busy, arvalid}, 0);
      end
      irq = 1'b0;
      @(negedge clk);
   endtask

   run_cfg_t tbl[16];
   int       n_runs;
   bit       found;

   initial begin
      #500000;
      $display("FAIL global_time_limit: simulation exceeded its time budget");
      $fatal(1, "time limit");
   end

   initial begin
      tbl[0] = mk(0, 0, 0, 0, 0, 8'h00, 32'd0);       // plain run, RDATA = 100*k
      tbl[1] = mk(3, 0, 1, 0, 0, 8'h00, 32'd0);       // slow AR, toggling ready
      tbl[2] = mk(0, 0, 0, 0, 0, 8'h08, 32'd7);       // SLVERR on register 3
      tbl[3] = mk(0, 1, 0, 0, 0, 8'h00, 32'd9);       // clean run clears error
      tbl[4] = mk(1, 1, 0, 1, 0, 8'h00, 32'd11);      // irq re-pulse, held high
      n_runs = 5;
      for (int i = 0; i < 6; i++) begin
         tbl[n_runs] = mk(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                          int'($urandom_range(0, 2)), 0, 0,
                          8'($urandom_range(0, 255)) & 8'h7E, $urandom);
         n_runs++;
      end

      // Reset state.
      repeat (3) @(negedge clk);
      chk(outputs_zero(), "reset_outputs", araddr, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk(outputs_zero() && !busy, "idle_after_reset", busy, 0);

      for (int i = 0; i < n_runs; i++) run_one(tbl[i], i);

      // Reset in the DATA phase of register 4, then restart from register 1.
      irq = 1'b1; arready = 1'b1; rvalid = 1'b0; rresp = 2'b00; result_ready = 1'b1;
      found = 0;
      for (int i = 0; i < 80 && !found; i++) begin
         @(negedge clk);
         if (rready && araddr == 10'(BASE + 16)) found = 1;
         rvalid = rready;
         rdata  = 32'h1234_0000 + 32'(i);
      end
      chk(found, "reach_data_reg4", found, 1);
      rst_n = 1'b0;
      #1;
      chk(outputs_zero(), "async_reset_outputs", {arvalid, rready, busy}, 0);
      irq = 1'b0; arready = 1'b0; rvalid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_one(mk(0, 0, 0, 0, 0, 8'h00, 32'd0), 90);

`ifdef FREQUENCY_READER_TIMEOUT_EN
      run_one(mk(0, 0, 0, 0, 2, 8'h00, 32'd0), 91);
      run_one(mk(0, 0, 0, 0, 0, 8'h00, 32'd5), 92);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
